// File: rtl/vicuna_ctrl_pkg.sv
// rtl/vicuna_ctrl_pkg.sv - shared constants and types for the Vicuna core controller
package vicuna_ctrl_pkg;

   localparam int unsigned SourceWidth = 8;

   localparam logic [31:0] OffCtrl         = 32'h00;
   localparam logic [31:0] OffStatus       = 32'h04;
   localparam logic [31:0] OffIntrState    = 32'h08;
   localparam logic [31:0] OffIntrEnable   = 32'h0C;
   localparam logic [31:0] OffBootAddrBase = 32'h10;
   localparam logic [31:0] OffCyclesBase   = 32'h40;

   localparam int unsigned CtrlStartBase = 0;
   localparam int unsigned CtrlAbortBase = 16;

   localparam logic [2:0] OpPutFull       = 3'd0;
   localparam logic [2:0] OpPutPartial    = 3'd1;
   localparam logic [2:0] OpGet           = 3'd4;
   localparam logic [2:0] OpAccessAck     = 3'd0;
   localparam logic [2:0] OpAccessAckData = 3'd1;

   typedef enum logic [1:0] {
      CoreIdle  = 2'd0,
      CoreReset = 2'd1,
      CoreRun   = 2'd2,
      CoreDone  = 2'd3
   } core_state_e;

endpackage

// File: rtl/vicuna_ctrl_if.sv
// rtl/vicuna_ctrl_if.sv - TL-UL register port bundle between host and controller
interface vicuna_ctrl_if;
   import vicuna_ctrl_pkg::*;

   logic                   a_valid;
   logic                   a_ready;
   logic [2:0]             a_opcode;
   logic [31:0]            a_address;
   logic [31:0]            a_data;
   logic [3:0]             a_mask;
   logic [1:0]             a_size;
   logic [SourceWidth-1:0] a_source;

   logic                   d_valid;
   logic                   d_ready;
   logic [2:0]             d_opcode;
   logic [31:0]            d_data;
   logic                   d_error;
   logic [1:0]             d_size;
   logic [SourceWidth-1:0] d_source;

   modport master (
      output a_valid, a_opcode, a_address, a_data, a_mask, a_size, a_source, d_ready,
      input  a_ready, d_valid, d_opcode, d_data, d_error, d_size, d_source
   );

   modport slave (
      input  a_valid, a_opcode, a_address, a_data, a_mask, a_size, a_source, d_ready,
      output a_ready, d_valid, d_opcode, d_data, d_error, d_size, d_source
   );

endinterface

// File: rtl/vicuna_ctrl_core_fsm.sv
// rtl/vicuna_ctrl_core_fsm.sv - per-core launch FSM, reset hold, boot shadow and run-cycle counter
module vicuna_ctrl_core_fsm
   import vicuna_ctrl_pkg::*;
#(
   parameter int unsigned ResetCycles = 8,
   parameter int unsigned CycleWidth  = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start,
   input  logic        abort,
   input  logic        core_done,
   input  logic [31:0] boot_addr,
   output core_state_e state,
   output logic [31:0] cycles,
   output logic        done_set,
   output logic        core_rst_n,
   output logic        fetch_en,
   output logic [31:0] core_boot_addr
);

   localparam int unsigned HoldWidth = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
   localparam logic [HoldWidth-1:0] HoldLast = HoldWidth'(ResetCycles - 1);

   core_state_e           state_q, state_d;
   logic [HoldWidth-1:0]  hold_q;
   logic [CycleWidth-1:0] cnt_q;
   logic [31:0]           shadow_q;
   logic                  enter_reset;

   always_comb begin
      state_d     = state_q;
      enter_reset = 1'b0;
      done_set    = 1'b0;
      unique case (state_q)
         CoreIdle, CoreDone: begin
            if (start && !abort) begin
               state_d     = CoreReset;
               enter_reset = 1'b1;
            end
         end
         CoreReset: begin
            if (hold_q == HoldLast) state_d = CoreRun;
         end
         CoreRun: begin
            if (core_done) begin
               state_d  = CoreDone;
               done_set = 1'b1;
            end
         end
         default: ;
      endcase
      // Abort overrides everything, including a completion seen in the same cycle.
      if (abort && state_q != CoreIdle) begin
         state_d  = CoreIdle;
         done_set = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= CoreIdle;
         hold_q   <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         state_q <= state_d;
         if (enter_reset) begin
            hold_q   <= '0;
            cnt_q    <= '0;
            shadow_q <= boot_addr;
         end else if (state_q == CoreReset && state_d == CoreReset) begin
            hold_q <= hold_q + HoldWidth'(1);
         end else if (state_q == CoreRun && state_d == CoreRun && !(&cnt_q)) begin
            cnt_q <= cnt_q + CycleWidth'(1);
         end
      end
   end

   assign state          = state_q;
   assign cycles         = 32'(cnt_q);
   assign core_rst_n     = (state_q == CoreRun);
   assign fetch_en       = (state_q == CoreRun);
   assign core_boot_addr = shadow_q;

endmodule

// File: rtl/vicuna_ctrl.sv
// rtl/vicuna_ctrl.sv - TL-UL register block that launches, supervises and stops Vicuna cores
module vicuna_ctrl
   import vicuna_ctrl_pkg::*;
#(
   parameter int unsigned NumCores        = 2,
   parameter int unsigned ResetCycles     = 8,
   parameter logic [31:0] DefaultBootAddr = 32'h0,
   parameter int unsigned CycleWidth      = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   vicuna_ctrl_if.slave           tl,
   output logic [NumCores-1:0]    core_rst_no,
   output logic [NumCores-1:0]    core_fetch_en_o,
   output logic [NumCores*32-1:0] core_boot_addr_o,
   input  logic [NumCores-1:0]    core_done_i,
   output logic                   intr_done_o
);

   logic                   rsp_valid_q;
   logic                   rsp_error_q;
   logic [2:0]             rsp_opcode_q;
   logic [31:0]            rsp_data_q;
   logic [1:0]             rsp_size_q;
   logic [SourceWidth-1:0] rsp_source_q;

   logic [NumCores-1:0]        intr_state_q;
   logic [NumCores-1:0]        intr_enable_q;
   logic                       intr_done_q;
   logic [NumCores-1:0][31:0]  boot_addr_q;
   logic [NumCores-1:0][31:0]  cycles;
   logic [NumCores-1:0][1:0]   core_state;

   logic [NumCores-1:0]   start, abort, done_set, boot_sel, intr_clr;
   logic [2*NumCores-1:0] status;
   logic                  accept, is_get, is_put, hit, ro, err, wr_ok;
   logic [31:0]           rdata;

   assign accept = tl.a_valid && tl.a_ready;
   assign is_get = (tl.a_opcode == OpGet);
   assign is_put = (tl.a_opcode == OpPutFull) || (tl.a_opcode == OpPutPartial);
   assign wr_ok  = accept && is_put && !err;

   always_comb begin
      hit      = 1'b0;
      ro       = 1'b0;
      rdata    = '0;
      boot_sel = '0;
      status   = '0;
      for (int n = 0; n < NumCores; n++) status[2*n +: 2] = core_state[n];
      case (tl.a_address)
         OffCtrl:       hit = 1'b1;
         OffStatus:     begin hit = 1'b1; ro = 1'b1; rdata = 32'(status); end
         OffIntrState:  begin hit = 1'b1; rdata = 32'(intr_state_q); end
         OffIntrEnable: begin hit = 1'b1; rdata = 32'(intr_enable_q); end
         default: ;
      endcase
      for (int n = 0; n < NumCores; n++) begin
         if (tl.a_address == OffBootAddrBase + 32'(4*n)) begin
            hit         = 1'b1;
            boot_sel[n] = 1'b1;
            rdata       = boot_addr_q[n];
         end
         if (tl.a_address == OffCyclesBase + 32'(4*n)) begin
            hit   = 1'b1;
            ro    = 1'b1;
            rdata = cycles[n];
         end
      end
      err = (tl.a_size != 2'd2) || !(is_get || is_put) || !hit ||
            (is_put && (tl.a_mask != 4'hF || ro));
   end

   always_comb begin
      start    = '0;
      abort    = '0;
      intr_clr = '0;
      for (int n = 0; n < NumCores; n++) begin
         start[n]    = wr_ok && (tl.a_address == OffCtrl) && tl.a_data[CtrlStartBase + n];
         abort[n]    = wr_ok && (tl.a_address == OffCtrl) && tl.a_data[CtrlAbortBase + n];
         intr_clr[n] = wr_ok && (tl.a_address == OffIntrState) && tl.a_data[n];
      end
   end

   for (genvar n = 0; n < NumCores; n++) begin : g_core
      vicuna_ctrl_core_fsm #(
         .ResetCycles (ResetCycles),
         .CycleWidth  (CycleWidth)
      ) u_fsm (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .start          (start[n]),
         .abort          (abort[n]),
         .core_done      (core_done_i[n]),
         .boot_addr      (boot_addr_q[n]),
         .state          (core_state[n]),
         .cycles         (cycles[n]),
         .done_set       (done_set[n]),
         .core_rst_n     (core_rst_no[n]),
         .fetch_en       (core_fetch_en_o[n]),
         .core_boot_addr (core_boot_addr_o[32*n +: 32])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_valid_q   <= 1'b0;
         rsp_error_q   <= 1'b0;
         rsp_opcode_q  <= '0;
         rsp_data_q    <= '0;
         rsp_size_q    <= '0;
         rsp_source_q  <= '0;
         intr_state_q  <= '0;
         intr_enable_q <= '0;
         intr_done_q   <= 1'b0;
         for (int n = 0; n < NumCores; n++) boot_addr_q[n] <= DefaultBootAddr;
      end else begin
         if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_error_q  <= err;
            rsp_opcode_q <= is_get ? OpAccessAckData : OpAccessAck;
            rsp_data_q   <= (is_get && !err) ? rdata : '0;
            rsp_size_q   <= tl.a_size;
            rsp_source_q <= tl.a_source;
         end else if (tl.d_ready) begin
            rsp_valid_q <= 1'b0;
         end
         if (wr_ok && tl.a_address == OffIntrEnable) intr_enable_q <= tl.a_data[NumCores-1:0];
         for (int n = 0; n < NumCores; n++) begin
            if (wr_ok && boot_sel[n]) boot_addr_q[n] <= tl.a_data;
         end
         // A completion landing in the same cycle as its W1C clear stays pending.
         intr_state_q <= (intr_state_q & ~intr_clr) | done_set;
         intr_done_q  <= |(intr_state_q & intr_enable_q);
      end
   end

   assign tl.a_ready   = !rsp_valid_q;
   assign tl.d_valid   = rsp_valid_q;
   assign tl.d_opcode  = rsp_opcode_q;
   assign tl.d_data    = rsp_data_q;
   assign tl.d_error   = rsp_error_q;
   assign tl.d_size    = rsp_size_q;
   assign tl.d_source  = rsp_source_q;
   assign intr_done_o  = intr_done_q;

endmodule

// File: tb/tb_vicuna_ctrl.sv
// tb/tb_vicuna_ctrl.sv - directed self-checking bench for vicuna_ctrl
module tb_vicuna_ctrl;
   import vicuna_ctrl_pkg::*;

   localparam logic [31:0] DefBoot  = 32'h2000_0000;
   localparam logic [31:0] OffBoot1 = 32'h14;
   localparam logic [31:0] OffCyc0  = 32'h40;
   localparam logic [31:0] OffCyc1  = 32'h44;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  core_rst_n, core_fetch_en, core_done;
   logic [63:0] core_boot_addr;
   logic        intr_done;
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  src = 8'd0;
   logic [31:0] rdat;
   logic        rerr;

   vicuna_ctrl_if tl ();

   vicuna_ctrl #(
      .NumCores        (2),
      .ResetCycles     (8),
      .DefaultBootAddr (DefBoot),
      .CycleWidth      (8)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .tl               (tl),
      .core_rst_no      (core_rst_n),
      .core_fetch_en_o  (core_fetch_en),
      .core_boot_addr_o (core_boot_addr),
      .core_done_i      (core_done),
      .intr_done_o      (intr_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [1:0] size,
                       output logic [31:0] data, output logic err);
      int k = 0;
      src          = src + 8'd1;
      tl.a_valid   = 1'b1;
      tl.a_opcode  = op;
      tl.a_address = addr;
      tl.a_data    = wdata;
      tl.a_mask    = mask;
      tl.a_size    = size;
      tl.a_source  = src;
      while (tl.a_ready !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("a_ready_wait", tl.a_ready, 1);
      @(negedge clk);
      tl.a_valid = 1'b0;
      check("d_valid", tl.d_valid, 1);
      check("d_source", tl.d_source, src);
      check("d_size", tl.d_size, size);
      check("d_opcode", tl.d_opcode, (op == OpGet) ? OpAccessAckData : OpAccessAck);
      data = tl.d_data;
      err  = tl.d_error;
   endtask

   task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] d;
      logic        e;
      xfer(OpPutFull, addr, wdata, 4'hF, 2'd2, d, e);
      check({tag, "_err"}, e, 0);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      xfer(OpGet, addr, 32'h0, 4'hF, 2'd2, d, e);
      check({tag, "_err"}, e, 0);
      check(tag, d, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      core_done = 2'b00;
      tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_address = '0; tl.a_data = '0;
      tl.a_mask = '0; tl.a_size = '0; tl.a_source = '0; tl.d_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_core_rst_n", core_rst_n, 2'b00);
      check("rst_fetch_en", core_fetch_en, 2'b00);
      check("rst_boot_addr", core_boot_addr, 64'h0);
      check("rst_intr", intr_done, 0);
      check("rst_d_valid", tl.d_valid, 0);
      check("rst_a_ready", tl.a_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);
      rd("status_reset", OffStatus, 32'h0);
      rd("boot0_reset", OffBootAddrBase, DefBoot);
      rd("boot1_reset", OffBoot1, DefBoot);

      // Launch core 1: reset held exactly 8 cycles
      wr("boot1_wr", OffBoot1, 32'h0000_1000);
      wr("ctrl_start1", OffCtrl, 32'h2);
      for (int i = 0; i < 8; i++) begin
         check("core1_rst_held", core_rst_n[1], 0);
         check("core1_fetch_off", core_fetch_en[1], 0);
         @(negedge clk);
      end
      check("core1_rst_release", core_rst_n[1], 1);
      check("core1_fetch_on", core_fetch_en[1], 1);
      check("core1_boot_addr", core_boot_addr[63:32], 32'h1000);
      check("core0_still_rst", core_rst_n[0], 0);
      rd("status_core1_run", OffStatus, 32'h8);

      // Core 0 runs 100 cycles then completes
      wr("ien_wr", OffIntrEnable, 32'h1);
      wr("ctrl_start0", OffCtrl, 32'h1);
      repeat (108) @(negedge clk);
      core_done[0] = 1'b1;
      @(negedge clk);
      core_done[0] = 1'b0;
      check("intr_latency_0", intr_done, 0);
      check("core0_done_rst", core_rst_n[0], 0);
      @(negedge clk);
      check("intr_latency_1", intr_done, 1);
      rd("status_done", OffStatus, 32'hB);
      rd("cycles0_100", OffCyc0, 32'd100);
      rd("istate_set", OffIntrState, 32'h1);
      wr("istate_w1c", OffIntrState, 32'h1);
      @(negedge clk);
      check("intr_cleared", intr_done, 0);
      rd("istate_clr", OffIntrState, 32'h0);

      // Abort, simultaneous start+abort, start-in-run, done-in-idle
      wr("abort_done", OffCtrl, 32'h0001_0000);
      rd("status_idle", OffStatus, 32'h8);
      rd("cycles0_kept", OffCyc0, 32'd100);
      wr("start_abort", OffCtrl, 32'h0001_0001);
      rd("status_abort_wins", OffStatus, 32'h8);
      core_done[0] = 1'b1;
      @(negedge clk);
      core_done[0] = 1'b0;
      rd("istate_idle_done", OffIntrState, 32'h0);
      wr("start0_again", OffCtrl, 32'h1);
      repeat (12) @(negedge clk);
      check("core0_run_fetch", core_fetch_en[0], 1);
      wr("start_in_run", OffCtrl, 32'h1);
      check("start_in_run_ign", core_rst_n[0], 1);
      rd("status_run0", OffStatus, 32'hA);
      wr("abort_run", OffCtrl, 32'h0001_0000);
      check("abort_rst_low", core_rst_n[0], 0);
      rd("status_abort_run", OffStatus, 32'h8);
      rd("istate_abort", OffIntrState, 32'h0);

      // Protocol errors
      xfer(OpPutPartial, OffIntrEnable, 32'h3, 4'h3, 2'd2, rdat, rerr);
      check("err_mask", rerr, 1);
      rd("ien_unchanged", OffIntrEnable, 32'h1);
      xfer(OpGet, 32'h80, 32'h0, 4'hF, 2'd2, rdat, rerr);
      check("err_unmapped", rerr, 1);
      check("err_unmapped_data", rdat, 32'h0);
      xfer(OpPutFull, OffStatus, 32'hF, 4'hF, 2'd2, rdat, rerr);
      check("err_ro", rerr, 1);
      rd("status_unchanged", OffStatus, 32'h8);
      xfer(OpGet, OffBoot1, 32'h0, 4'hF, 2'd1, rdat, rerr);
      check("err_size", rerr, 1);
      check("err_size_data", rdat, 32'h0);
      xfer(OpPutPartial, OffCtrl, 32'h1, 4'h1, 2'd2, rdat, rerr);
      check("err_ctrl_mask", rerr, 1);
      check("err_ctrl_no_start", core_rst_n[0], 0);

      // Response back-pressure
      @(negedge clk);
      tl.d_ready = 1'b0;
      src = src + 8'd1;
      tl.a_valid = 1'b1; tl.a_opcode = OpGet; tl.a_address = OffBoot1;
      tl.a_mask = 4'hF; tl.a_size = 2'd2; tl.a_source = src;
      @(negedge clk);
      tl.a_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_a_ready", tl.a_ready, 0);
         check("stall_d_valid", tl.d_valid, 1);
         check("stall_d_data", tl.d_data, 32'h1000);
         @(negedge clk);
      end
      tl.d_ready = 1'b1;
      @(negedge clk);
      check("stall_release_valid", tl.d_valid, 0);
      check("stall_release_ready", tl.a_ready, 1);

      // Saturation of the (8-bit) run counter on core 1
      repeat (300) @(negedge clk);
      rd("cycles1_sat", OffCyc1, 32'hFF);
      repeat (20) @(negedge clk);
      rd("cycles1_sat_hold", OffCyc1, 32'hFF);

      // Boot address shadowing, restart from DONE, reset mid-run
      wr("boot1_wr_run", OffBoot1, 32'h0000_3000);
      check("shadow_kept", core_boot_addr[63:32], 32'h1000);
      rd("boot1_reg_new", OffBoot1, 32'h3000);
      wr("ien_both", OffIntrEnable, 32'h3);
      wr("start0_final", OffCtrl, 32'h1);
      repeat (12) @(negedge clk);
      check("core0_boot_default", core_boot_addr[31:0], DefBoot);
      core_done[0] = 1'b1;
      @(negedge clk);
      core_done[0] = 1'b0;
      @(negedge clk);
      check("intr_before_rst", intr_done, 1);
      wr("restart_from_done", OffCtrl, 32'h1);
      repeat (12) @(negedge clk);
      check("both_run", core_rst_n, 2'b11);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_core_rst_n", core_rst_n, 2'b00);
      check("mid_rst_fetch", core_fetch_en, 2'b00);
      check("mid_rst_boot", core_boot_addr, 64'h0);
      check("mid_rst_intr", intr_done, 0);
      check("mid_rst_d_valid", tl.d_valid, 0);
      check("mid_rst_a_ready", tl.a_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);
      rd("boot1_after_rst", OffBoot1, DefBoot);
      rd("cycles1_after_rst", OffCyc1, 32'h0);
      rd("ien_after_rst", OffIntrEnable, 32'h0);
      rd("status_after_rst", OffStatus, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
